// File: rtl/lcl_wr_burst_splitter.sv
// lcl_wr_burst_splitter: splits a write job into 4 KB-safe bursts of at most MAX_BURST beats
// and drives the write master's lcl_* local-bus protocol.
module lcl_wr_burst_splitter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512,
  parameter int MAX_BURST  = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  job_start,
  input  logic [ADDR_WIDTH-1:0] job_addr,
  input  logic [CNT_WIDTH-1:0]  job_beats,
  output logic                  job_busy,
  output logic                  job_done,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_ready,
  input  logic                  lcl_ibusy,
  output logic                  lcl_istart,
  output logic [ADDR_WIDTH-1:0] lcl_iaddr,
  output logic [7:0]            lcl_inum,
  input  logic                  lcl_irdy,
  output logic                  lcl_den,
  output logic [DATA_WIDTH-1:0] lcl_din,
  output logic                  lcl_idone,
  output logic [15:0]           burst_cnt
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, DATA = 2'd2, DRAIN = 2'd3;
  logic [1:0] state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [CNT_WIDTH-1:0] remaining;
  logic [6:0] beat_left, room, cap, len;
  logic hs, last;
  // room = beats left before the next 4 KB boundary (1..64)
  always_comb begin
    room = 7'd64 - {1'b0, cur_addr[11:6]};
    cap = (7'(MAX_BURST) < room) ? 7'(MAX_BURST) : room;
    len = (remaining < CNT_WIDTH'(cap)) ? remaining[6:0] : cap;
  end
  assign src_ready = state == DATA && lcl_irdy && beat_left != 7'd0;
  assign hs = src_valid && src_ready;
  assign last = hs && beat_left == 7'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cur_addr <= '0;
      remaining <= '0;
      beat_left <= '0;
      job_busy <= 1'b0;
      job_done <= 1'b0;
      burst_cnt <= '0;
      lcl_istart <= 1'b0;
      lcl_iaddr <= '0;
      lcl_inum <= '0;
      lcl_den <= 1'b0;
      lcl_din <= '0;
      lcl_idone <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      job_busy <= 1'b0;
      job_done <= 1'b0;
      lcl_istart <= 1'b0;
      lcl_den <= 1'b0;
      lcl_idone <= 1'b0;
    end else begin
      lcl_istart <= 1'b0;
      job_done <= 1'b0;
      lcl_den <= hs;
      lcl_idone <= last;
      if (hs) begin
        lcl_din <= src_data;
        beat_left <= beat_left - 7'd1;
      end
      case (state)
        IDLE: if (job_start) begin
          cur_addr <= {job_addr[ADDR_WIDTH-1:6], 6'b0};
          remaining <= job_beats;
          job_busy <= 1'b1;
          burst_cnt <= '0;
          state <= job_beats == '0 ? DRAIN : REQ;
        end
        REQ: if (!lcl_ibusy) begin
          lcl_istart <= 1'b1;
          lcl_iaddr <= cur_addr;
          lcl_inum <= {1'b0, len};
          beat_left <= len;
          burst_cnt <= burst_cnt + 16'(burst_cnt != 16'hFFFF);
          state <= DATA;
        end
        DATA: if (last) begin
          cur_addr <= cur_addr + (ADDR_WIDTH'(len) << 6);
          remaining <= remaining - CNT_WIDTH'(len);
          state <= remaining == CNT_WIDTH'(len) ? DRAIN : REQ;
        end
        default: if (!lcl_ibusy) begin
          job_done <= 1'b1;
          job_busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_lcl_wr_burst_splitter.sv
// tb_lcl_wr_burst_splitter: table-driven jobs under random data/backpressure, checked against
// a burst-list reference model and a simple write-master responder.
module tb_lcl_wr_burst_splitter;
  localparam int AW = 64, DW = 512, MB = 64, CW = 32;
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, job_start = 1'b0;
  logic [AW-1:0] job_addr = '0;
  logic [CW-1:0] job_beats = '0;
  logic job_busy, job_done, src_ready, lcl_istart, lcl_den, lcl_idone;
  logic src_valid = 1'b0, lcl_ibusy = 1'b0, lcl_irdy = 1'b0;
  logic [DW-1:0] src_data = '0, lcl_din;
  logic [AW-1:0] lcl_iaddr;
  logic [7:0] lcl_inum;
  logic [15:0] burst_cnt;

  lcl_wr_burst_splitter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .job_start(job_start), .job_addr(job_addr),
    .job_beats(job_beats), .job_busy(job_busy), .job_done(job_done), .src_valid(src_valid),
    .src_data(src_data), .src_ready(src_ready), .lcl_ibusy(lcl_ibusy), .lcl_istart(lcl_istart),
    .lcl_iaddr(lcl_iaddr), .lcl_inum(lcl_inum), .lcl_irdy(lcl_irdy), .lcl_den(lcl_den),
    .lcl_din(lcl_din), .lcl_idone(lcl_idone), .burst_cnt(burst_cnt));

  always #5 clk = ~clk;

  typedef struct { logic [63:0] addr; int num; } burst_t;
  typedef struct { logic [63:0] addr; logic [31:0] beats; int mode; int nb; logic [63:0] fa; int fn; } vec_t;
  burst_t eb[$];
  vec_t vecs[8];
  int errors = 0, checks = 0;
  int mode = 0, n_start = 0, n_den = 0, n_idone = 0, n_done = 0, cur_num = 0, in_burst = 0, hold = 0, fn = 0;
  logic [63:0] fa = '0;
  bit first_pending = 0;
  logic s_hs = 0, s_clr = 0, s_rst = 0, s_js = 0;
  logic [DW-1:0] s_data = '0, din_hold = '0;
  logic [AW-1:0] s_addr = '0;
  logic [CW-1:0] s_beats = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk the job in whole bursts, each limited by MAX_BURST, what is left and the 4 KB page.
  function automatic void build(input logic [63:0] a, input logic [31:0] n);
    longint rem;
    logic [63:0] p;
    int room, len;
    rem = longint'(n);
    p = a & ~64'h3F;
    while (rem > 0) begin
      room = int'((64'd4096 - (p % 64'd4096)) / 64'd64);
      len = rem < MB ? int'(rem) : MB;
      if (room < len) len = room;
      eb.push_back('{p, len});
      p = p + 64'(len) * 64'd64;
      rem = rem - len;
    end
  endfunction

  task automatic monitor();
    burst_t b;
    if (!s_rst || s_clr) begin
      eb.delete();
      lcl_ibusy = 1'b0;
      hold = 0;
      in_burst = 0;
      cur_num = 0;
      if (!s_rst) din_hold = '0;
    end
    if (s_js) build(s_addr, s_beats);
    if (lcl_istart) begin
      n_start++;
      chk("istart_while_busy", lcl_ibusy, 0);
      if (first_pending) begin
        fa = lcl_iaddr;
        fn = lcl_inum;
        first_pending = 0;
      end
      chk("burst_expected", eb.size() != 0, 1);
      if (eb.size() != 0) begin
        b = eb.pop_front();
        chk("iaddr", lcl_iaddr, b.addr);
        chk("inum", lcl_inum, b.num);
        cur_num = b.num;
      end
      lcl_ibusy = 1'b1;
      in_burst = 0;
    end
    chk("den", lcl_den, s_hs);
    if (s_hs) din_hold = s_data;
    chk("din", lcl_din, din_hold);
    if (s_hs) in_burst++;
    chk("idone", lcl_idone, s_hs && in_burst == cur_num);
    if (lcl_den) n_den++;
    if (lcl_idone) begin
      n_idone++;
      hold = $urandom_range(1, 4);
    end else if (hold > 0) begin
      hold--;
      if (hold == 0) lcl_ibusy = 1'b0;
    end
    if (job_done) n_done++;
  endtask

  // Called at negedge+1; samples just before the posedge, checks/drives at the next negedge.
  task automatic step();
    #3;
    s_hs = src_valid && src_ready && !clear && rst_n;
    s_data = src_data;
    s_clr = clear;
    s_rst = rst_n;
    s_js = job_start && !clear && rst_n;
    s_addr = job_addr;
    s_beats = job_beats;
    chk("ready_without_irdy", src_ready && !lcl_irdy, 0);
    @(negedge clk);
    monitor();
    lcl_irdy = mode == 0 ? 1'b1 : mode == 1 ? ~lcl_irdy : 1'($urandom_range(0, 1));
    src_valid = mode == 0 ? 1'b1 : 1'($urandom_range(0, 1));
    for (int i = 0; i < DW / 32; i++) src_data[i*32 +: 32] = $urandom();
    #1;
  endtask

  task automatic run_job(input vec_t t);
    int s0, d0, n0;
    s0 = n_start;
    d0 = n_done;
    n0 = n_den;
    mode = t.mode;
    job_addr = t.addr;
    job_beats = t.beats;
    job_start = 1'b1;
    first_pending = 1;
    step();
    job_start = 1'b0;
    chk("busy_after_start", job_busy, 1);
    for (int c = 0; c < 5000 && n_done == d0; c++) step();
    repeat (3) step();
    chk("done_pulses", n_done - d0, 1);
    chk("bursts", n_start - s0, t.nb);
    chk("beats", n_den - n0, t.beats);
    chk("burst_cnt", burst_cnt, t.nb);
    chk("busy_end", job_busy, 0);
    chk("bursts_left", eb.size(), 0);
    if (t.nb > 0) begin
      chk("first_addr", fa, t.fa);
      chk("first_num", fn, t.fn);
    end
  endtask

  initial begin
    int d0, n0;
    vecs[0] = '{64'h1000, 32'd4, 0, 1, 64'h1000, 4};
    vecs[1] = '{64'h0FC0, 32'd10, 0, 2, 64'h0FC0, 1};
    vecs[2] = '{64'h0, 32'd200, 2, 4, 64'h0, 64};
    vecs[3] = '{64'h2000, 32'd8, 1, 1, 64'h2000, 8};
    vecs[4] = '{64'h0, 32'd0, 0, 0, 64'h0, 0};
    vecs[5] = '{64'h1FFF, 32'd3, 2, 2, 64'h1FC0, 1};
    vecs[6] = '{64'hFFFF_FFFF_FFFF_FFC0, 32'd2, 0, 2, 64'hFFFF_FFFF_FFFF_FFC0, 1};
    vecs[7] = '{64'h12340, 32'd150, 2, 3, 64'h12340, 51};
    repeat (3) @(negedge clk);
    #1;
    chk("rst_istart", lcl_istart, 0);
    chk("rst_iaddr", lcl_iaddr, 0);
    chk("rst_inum", lcl_inum, 0);
    chk("rst_den", lcl_den, 0);
    chk("rst_din", lcl_din, 0);
    chk("rst_idone", lcl_idone, 0);
    chk("rst_busy", job_busy, 0);
    chk("rst_done", job_done, 0);
    chk("rst_burst_cnt", burst_cnt, 0);
    chk("rst_src_ready", src_ready, 0);
    rst_n = 1'b1;
    repeat (2) step();
    for (int k = 0; k < 8; k++) run_job(vecs[k]);
    // zero-beat job: done two cycles after the request
    mode = 0;
    job_addr = 64'h40;
    job_beats = '0;
    job_start = 1'b1;
    step();
    job_start = 1'b0;
    chk("zero_done_early", job_done, 0);
    chk("zero_busy", job_busy, 1);
    step();
    chk("zero_done", job_done, 1);
    chk("zero_busy_end", job_busy, 0);
    step();
    chk("zero_done_once", job_done, 0);
    chk("zero_no_istart", burst_cnt, 0);
    // clear after three beats of a 16-beat job
    d0 = n_done;
    n0 = n_den;
    job_addr = 64'h4000;
    job_beats = 32'd16;
    job_start = 1'b1;
    step();
    job_start = 1'b0;
    for (int c = 0; c < 200 && n_den - n0 < 3; c++) step();
    chk("clear_reached_3", n_den - n0, 3);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_busy", job_busy, 0);
    chk("clear_ready", src_ready, 0);
    n0 = n_den;
    repeat (10) step();
    chk("clear_no_den", n_den - n0, 0);
    chk("clear_no_done", n_done - d0, 0);
    run_job(vecs[1]);
    // asynchronous reset in the middle of a burst
    n0 = n_den;
    job_addr = 64'h8000;
    job_beats = 32'd16;
    job_start = 1'b1;
    step();
    job_start = 1'b0;
    for (int c = 0; c < 200 && n_den - n0 < 2; c++) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", job_busy, 0);
    chk("mid_rst_den", lcl_den, 0);
    chk("mid_rst_din", lcl_din, 0);
    chk("mid_rst_iaddr", lcl_iaddr, 0);
    chk("mid_rst_inum", lcl_inum, 0);
    chk("mid_rst_burst_cnt", burst_cnt, 0);
    @(negedge clk);
    #1;
    step();
    rst_n = 1'b1;
    repeat (2) step();
    run_job(vecs[0]);
    run_job(vecs[7]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lcl_wr_burst_splitter.md
Name: lcl_wr_burst_splitter

Overview:
- Sits directly upstream of the AXI write master, on its local-bus side.
- Accepts one write job (start address, total 64-byte beats) plus a valid/ready data stream from the action logic.
- Splits the job into bursts of at most MAX_BURST beats that never cross a 4 KB boundary.
- Drives the master's lcl_istart/lcl_iaddr/lcl_inum/lcl_den/lcl_din/lcl_idone protocol and reports job completion once the master has drained.

Parameters:
ADDR_WIDTH, 64, byte address width
DATA_WIDTH, 512, beat width; one beat = 64 bytes
MAX_BURST, 64, max beats per burst, legal range 1..64
CNT_WIDTH, 32, width of the job beat count

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
clear  in  1  synchronous abort, returns FSM to IDLE
job_start  in  1  one-cycle job request, honoured only in IDLE
job_addr  in  ADDR_WIDTH  job start byte address; bits [5:0] ignored (treated as 0)
job_beats  in  CNT_WIDTH  total beats in the job
job_busy  out  1  high from job acceptance until job_done
job_done  out  1  one-cycle pulse at job completion
src_valid  in  1  upstream data valid
src_data  in  DATA_WIDTH  upstream data
src_ready  out  1  upstream data ready (combinational)
lcl_ibusy  in  1  write master busy
lcl_istart  out  1  burst start pulse, registered
lcl_iaddr  out  ADDR_WIDTH  burst byte address, registered
lcl_inum  out  8  burst beat count (1..MAX_BURST), registered
lcl_irdy  in  1  write master FIFO can accept data
lcl_den  out  1  data enable, registered
lcl_din  out  DATA_WIDTH  data, registered
lcl_idone  out  1  asserted with the last lcl_den of each burst, registered
burst_cnt  out  16  bursts issued in the current job; saturates at 16'hFFFF; cleared on job_start

Behaviour:
- Reset values: every output and all internal state are 0 (lcl_iaddr, lcl_inum, lcl_din, burst_cnt included); FSM = IDLE.
- FSM states: IDLE, REQ, DATA, DRAIN.
- IDLE, on job_start:
  - latch cur_addr = {job_addr[ADDR_WIDTH-1:6], 6'b0} and remaining = job_beats.
  - job_busy <= 1; burst_cnt <= 0.
  - if job_beats == 0: go to DRAIN (no burst is issued).
  - otherwise: go to REQ.
- Burst length: len = min(MAX_BURST, remaining, 64 - cur_addr[11:6]). This is computed combinationally from registers; the result is always in 1..64.
- REQ:
  - wait while lcl_ibusy = 1.
  - when lcl_ibusy = 0: lcl_istart <= 1 for exactly one cycle, with lcl_iaddr <= cur_addr and lcl_inum <= len; latch beat_left = len; burst_cnt++; go to DATA.
- DATA:
  - src_ready = (state == DATA) & lcl_irdy & (beat_left != 0).
  - on each src_valid & src_ready: next cycle lcl_den = 1 and lcl_din = src_data (1-cycle latency); beat_left--.
  - lcl_idone is asserted in the same cycle as the lcl_den carrying the final beat of the burst.
  - lcl_den is 0 on every cycle with no handshake; lcl_din holds its last value.
- After the final beat handshake of a burst:
  - cur_addr += len*64; remaining -= len.
  - if remaining == 0: go to DRAIN; otherwise go to REQ.
- Ordering guarantee: lcl_ibusy rises one cycle after lcl_istart, and DATA lasts at least one cycle, so REQ always observes the busy from the previous burst.
- DRAIN: wait for lcl_ibusy = 0, then pulse job_done, set job_busy <= 0, go to IDLE. For a zero-beat job, job_done arrives 2 cycles after job_start when lcl_ibusy = 0.
- Backpressure: lcl_irdy is sampled combinationally into src_ready. The master's FIFO margin absorbs the one registered beat in flight.
- job_start outside IDLE is ignored.
- Arithmetic: address wraps modulo 2^ADDR_WIDTH; remaining never underflows because len <= remaining.
- clear (any state):
  - FSM -> IDLE; job_busy, lcl_istart, lcl_den, lcl_idone <= 0.
  - no job_done is issued; the partial burst is abandoned (the master is cleared by the same signal).
- Reset mid-operation: everything returns immediately to reset values.

Test Plan:
- job_addr=0x1000, job_beats=4, lcl_irdy=1, src always valid -> one lcl_istart with iaddr=0x1000, inum=4; 4 lcl_den, with lcl_idone on the 4th; job_done once after lcl_ibusy falls; burst_cnt=1.
- job_addr=0x0FC0, job_beats=10 -> bursts (0x0FC0, 1) then (0x1000, 9); lcl_idone twice; burst_cnt=2.
- job_addr=0x0, job_beats=200, MAX_BURST=64 -> bursts of 64/64/64/8 at 0x0/0x1000/0x2000/0x3000; second lcl_istart not issued until lcl_ibusy = 0.
- lcl_irdy toggled 1,0,1,0 and src_valid randomized over an 8-beat burst -> src_ready never high while lcl_irdy = 0; exactly 8 lcl_den; data order preserved.
- job_beats=0 -> no lcl_istart; job_done pulses 2 cycles after job_start with lcl_ibusy=0.
- clear after 3 of 16 beats -> state IDLE next cycle, no further lcl_den, no job_done; a new job_start is then accepted normally.
